// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation search controller and its helpers.
package me_pkg;

    // Default search geometry and SAD pipeline depth
    localparam int ME_SR       = 16;
    localparam int ME_MV_W     = 6;
    localparam int ME_PIPE_LAT = 4;

    // Search controller states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        SCAN  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } me_state_e;

    // Signed motion-vector component at the default width
    typedef logic signed [ME_MV_W-1:0] mv_t;

    // Candidate counter width: enough to hold (2*SR)^2 plus one spare bit
    function automatic int cand_cnt_width(input int sr);
        return $clog2((2 * sr) * (2 * sr)) + 1;
    endfunction

endpackage

// File: rtl/sad_tag_delay.sv
// Fixed-depth shift register that carries {valid, mvx, mvy} alongside the SAD pipeline.
// It never stalls, so a tag issued at cycle t appears at the output at cycle t+DEPTH.
module sad_tag_delay #(
    parameter int MV_W  = 6,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    input  logic signed [MV_W-1:0] i_mvx,
    input  logic signed [MV_W-1:0] i_mvy,
    output logic                   o_valid,
    output logic signed [MV_W-1:0] o_mvx,
    output logic signed [MV_W-1:0] o_mvy
);

    logic                   r_valid [DEPTH];
    logic signed [MV_W-1:0] r_mvx   [DEPTH];
    logic signed [MV_W-1:0] r_mvy   [DEPTH];

    // Shift the tags one stage per cycle; reset flushes every stage
    // NOTE: this array is a handful of flops, not a RAM, so it is reset; otherwise
    // stale valid bits left over from an aborted search could raise cmp_en after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_mvx[i]   <= '0;
                r_mvy[i]   <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_mvx[0]   <= i_mvx;
            r_mvy[0]   <= i_mvy;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_mvx[i]   <= r_mvx[i-1];
                r_mvy[i]   <= r_mvy[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_mvx   = r_mvx[DEPTH-1];
    assign o_mvy   = r_mvy[DEPTH-1];

endmodule

// File: rtl/sad_search_ctrl.sv
// Full-search motion-estimation sequencer: steps candidate MVs in raster order over
// [-SR, SR-1]^2, clears the SAD min-comparator before the first candidate, and delays
// each candidate's valid/MV tag by the SAD pipeline depth so the comparator sees them
// together with the matching SAD.
module sad_search_ctrl
    import me_pkg::*;
#(
    parameter int SR       = ME_SR,
    parameter int MV_W     = ME_MV_W,
    parameter int PIPE_LAT = ME_PIPE_LAT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stall,
    output logic                   cmp_clear,
    output logic                   cand_valid,
    output logic signed [MV_W-1:0] cand_mvx,
    output logic signed [MV_W-1:0] cand_mvy,
    output logic                   cmp_en,
    output logic signed [MV_W-1:0] cmp_mvx,
    output logic signed [MV_W-1:0] cmp_mvy,
    output logic                   busy,
    output logic                   done
);

    localparam int N_CAND = (2 * SR) * (2 * SR);
    localparam int CNT_W  = cand_cnt_width(SR);
    localparam int DRN_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic signed [MV_W-1:0] MV_MIN = MV_W'(-SR);
    localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(SR - 1);
    localparam logic signed [MV_W-1:0] MV_ONE = MV_W'(1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CAND - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(PIPE_LAT - 1);
    localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);

    me_state_e              r_state;
    logic [CNT_W-1:0]       r_cand_cnt;
    logic [DRN_W-1:0]       r_drain_cnt;
    logic signed [MV_W-1:0] r_mvx;
    logic signed [MV_W-1:0] r_mvy;
    logic                   r_cmp_clear;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_cand_valid;
    logic                   w_last_issue;

    // A candidate goes out in any SCAN cycle whose reference pixels are ready. This is
    // deliberately combinational on stall: a registered version would issue one cycle
    // after the pixels stopped being ready.
    assign w_cand_valid = (r_state == SCAN) && !stall;
    assign w_last_issue = w_cand_valid && (r_cand_cnt == CNT_LAST);

    // Search FSM with MV stepping, candidate count, drain countdown and registered flags
    // NOTE: every register in a clocked block takes <=, so all right-hand sides read the
    // values from before this edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cand_cnt  <= '0;
            r_drain_cnt <= '0;
            r_mvx       <= MV_MIN;
            r_mvy       <= MV_MIN;
            r_cmp_clear <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Single-cycle pulses fall back to 0 unless re-raised below
            r_cmp_clear <= 1'b0;
            r_done      <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= INIT;
                        r_cmp_clear <= 1'b1;
                        r_busy      <= 1'b1;
                        r_mvx       <= MV_MIN;
                        r_mvy       <= MV_MIN;
                        r_cand_cnt  <= '0;
                    end
                end

                INIT: begin
                    r_state <= SCAN;
                end

                SCAN: begin
                    if (w_cand_valid) begin
                        r_cand_cnt <= r_cand_cnt + CNT_ONE;
                        if (r_mvx == MV_MAX) begin
                            r_mvx <= MV_MIN;
                            r_mvy <= (r_mvy == MV_MAX) ? MV_MIN : (r_mvy + MV_ONE);
                        end else begin
                            r_mvx <= r_mvx + MV_ONE;
                        end
                        if (w_last_issue) begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= DRN_LOAD;
                        end
                    end
                end

                DRAIN: begin
                    // The last tag reaches cmp_en in the cycle the counter reads 0
                    if (r_drain_cnt == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DRN_ONE;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    sad_tag_delay #(
        .MV_W  (MV_W),
        .DEPTH (PIPE_LAT)
    ) u_tag_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_cand_valid),
        .i_mvx   (r_mvx),
        .i_mvy   (r_mvy),
        .o_valid (cmp_en),
        .o_mvx   (cmp_mvx),
        .o_mvy   (cmp_mvy)
    );

    assign cmp_clear  = r_cmp_clear;
    assign cand_valid = w_cand_valid;
    assign cand_mvx   = r_mvx;
    assign cand_mvy   = r_mvy;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
